// File: rtl/wt_fifo_pkg.sv
// wt_fifo_pkg: shared defaults, grant encoding and Gray conversion for the write-side FIFO logic
package wt_fifo_pkg;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    typedef enum logic {GNT_A, GNT_B} gnt_t;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/ptr_sync_2ff.sv
// ptr_sync_2ff: two-flop synchronizer for a Gray pointer (clk, rst_n async low, d in, q synchronized out)
module ptr_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/wt_port_arb.sv
// wt_port_arb: two-requester round-robin write port for an async FIFO
// Ports: wt_clk_arb/rst_n_wt_arb_in clock and async low reset; req_*/data_* requests and data;
// gnt_* combinational accepts; wt_en_out/wt_addr_out/wt_data_out registered memory write;
// rd_ptr_gray_in foreign-domain Gray read pointer; wt_ptr_gray_out Gray write pointer;
// wt_full registered full flag; wt_drop_cnt saturating count of refused request cycles.
module wt_port_arb
    import wt_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  wt_clk_arb,
    input  logic                  rst_n_wt_arb_in,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray_in,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  wt_en_out,
    output logic [ADDR_WIDTH-1:0] wt_addr_out,
    output logic [DATA_WIDTH-1:0] wt_data_out,
    output logic [ADDR_WIDTH:0]   wt_ptr_gray_out,
    output logic                  wt_full,
    output logic [7:0]            wt_drop_cnt
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [PW-1:0] wptr_bin, wptr_next, wgray_next, rsync, full_cmp;
    gnt_t last_gnt;
    logic req_any, accept, pick_b;
    ptr_sync_2ff #(.WIDTH(PW)) u_rsync (
        .clk   (wt_clk_arb),
        .rst_n (rst_n_wt_arb_in),
        .d     (rd_ptr_gray_in),
        .q     (rsync)
    );
    assign req_any    = req_a | req_b;
    // reset gates the grants so nothing is offered while reset is held
    assign accept     = rst_n_wt_arb_in & req_any & ~wt_full;
    assign pick_b     = req_b & (~req_a | (last_gnt == GNT_A));
    assign gnt_a      = accept & ~pick_b;
    assign gnt_b      = accept & pick_b;
    assign wptr_next  = wptr_bin + PW'(accept);
    assign wgray_next = PW'(bin2gray(32'(wptr_next)));
    // full when the write pointer is exactly one lap ahead of the synchronized read pointer
    assign full_cmp   = {~rsync[PW-1:PW-2], rsync[PW-3:0]};
    always_ff @(posedge wt_clk_arb or negedge rst_n_wt_arb_in) begin
        if (!rst_n_wt_arb_in) begin
            wptr_bin        <= '0;
            wt_ptr_gray_out <= '0;
            wt_full         <= 1'b0;
            wt_en_out       <= 1'b0;
            wt_addr_out     <= '0;
            wt_data_out     <= '0;
            wt_drop_cnt     <= '0;
            last_gnt        <= GNT_B;
        end else begin
            wptr_bin        <= wptr_next;
            wt_ptr_gray_out <= wgray_next;
            wt_full         <= wgray_next == full_cmp;
            wt_en_out       <= accept;
            if (accept) begin
                wt_addr_out <= wptr_bin[ADDR_WIDTH-1:0];
                wt_data_out <= pick_b ? data_b : data_a;
                last_gnt    <= pick_b ? GNT_B : GNT_A;
            end
            if (req_any && wt_full && wt_drop_cnt != 8'hFF)
                wt_drop_cnt <= wt_drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_wt_port_arb.sv
// tb_wt_port_arb: table, directed and random checks of wt_port_arb against an occupancy-based model
module tb_wt_port_arb;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] data_a = '0, data_b = '0;
    logic [4:0] rd_gray = '0;
    logic       gnt_a, gnt_b, wt_en_out, wt_full;
    logic [3:0] wt_addr_out;
    logic [7:0] wt_data_out, wt_drop_cnt;
    logic [4:0] wt_ptr_gray_out;

    wt_port_arb dut (
        .wt_clk_arb      (clk),
        .rst_n_wt_arb_in (rst_n),
        .req_a           (req_a),
        .req_b           (req_b),
        .data_a          (data_a),
        .data_b          (data_b),
        .rd_ptr_gray_in  (rd_gray),
        .gnt_a           (gnt_a),
        .gnt_b           (gnt_b),
        .wt_en_out       (wt_en_out),
        .wt_addr_out     (wt_addr_out),
        .wt_data_out     (wt_data_out),
        .wt_ptr_gray_out (wt_ptr_gray_out),
        .wt_full         (wt_full),
        .wt_drop_cnt     (wt_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    // model: write count, read position, delayed view of the read position
    int m_w, m_rd, m_r1, m_r2, m_drop, m_addr, m_data;
    bit m_full, m_en, m_last;
    logic s_ga, s_gb;

    typedef struct {
        bit         a, b;
        bit         ga, gb, en;
        logic [3:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic model_reset();
        m_w = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_drop = 0; m_addr = 0; m_data = 0;
        m_full = 0; m_en = 0; m_last = 1;
    endtask

    task automatic step(input bit a, input bit b, input logic [7:0] da, input logic [7:0] db, input int rdb);
        bit acc, wb;
        @(negedge clk);
        req_a = a; req_b = b; data_a = da; data_b = db; rd_gray = gray5(rdb);
        #1;
        acc = (a | b) && !m_full;
        wb  = b && (!a || !m_last);
        s_ga = gnt_a; s_gb = gnt_b;
        chk("gnt_a", gnt_a, 32'(acc && !wb));
        chk("gnt_b", gnt_b, 32'(acc && wb));
        @(posedge clk);
        if (acc) begin
            m_en = 1; m_addr = m_w % 16; m_data = wb ? db : da; m_w = (m_w + 1) % 32; m_last = wb;
        end else m_en = 0;
        if ((a | b) && m_full && m_drop < 255) m_drop++;
        m_full = ((m_w - m_r2) & 31) == 16;
        m_r2 = m_r1; m_r1 = rdb;
        #1;
        chk("wt_en_out", wt_en_out, 32'(m_en));
        chk("wt_addr_out", wt_addr_out, 32'(m_addr));
        chk("wt_data_out", wt_data_out, 32'(m_data));
        chk("wt_ptr_gray_out", wt_ptr_gray_out, 32'(gray5(m_w)));
        chk("wt_full", wt_full, 32'(m_full));
        chk("wt_drop_cnt", wt_drop_cnt, 32'(m_drop));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt_a"}, gnt_a, 0);
        chk({tag, "_gnt_b"}, gnt_b, 0);
        chk({tag, "_en"}, wt_en_out, 0);
        chk({tag, "_addr"}, wt_addr_out, 0);
        chk({tag, "_data"}, wt_data_out, 0);
        chk({tag, "_gray"}, wt_ptr_gray_out, 0);
        chk({tag, "_full"}, wt_full, 0);
        chk({tag, "_drop"}, wt_drop_cnt, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        req_a = 1; req_b = 1;
        rst_n = 0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        req_a = 0; req_b = 0; rd_gray = '0;
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{1, 0, 1, 0, 1, 4'd0, 8'h10};
        vecs[1] = '{0, 1, 0, 1, 1, 4'd1, 8'h81};
        vecs[2] = '{1, 1, 1, 0, 1, 4'd2, 8'h12};
        vecs[3] = '{1, 1, 0, 1, 1, 4'd3, 8'h83};
        vecs[4] = '{0, 0, 0, 0, 0, 4'd3, 8'h83};
        vecs[5] = '{1, 1, 1, 0, 1, 4'd4, 8'h15};
        vecs[6] = '{1, 0, 1, 0, 1, 4'd5, 8'h16};
        vecs[7] = '{1, 1, 0, 1, 1, 4'd6, 8'h87};
        vecs[8] = '{0, 1, 0, 1, 1, 4'd7, 8'h88};
        vecs[9] = '{1, 1, 1, 0, 1, 4'd8, 8'h19};
        model_reset();
        #7 rst_n = 1;
        #1 check_zero("reset");
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].a, vecs[i].b, 8'(8'h10 + i), 8'(8'h80 + i), 0);
            chk("vec_gnt_a", s_ga, 32'(vecs[i].ga));
            chk("vec_gnt_b", s_gb, 32'(vecs[i].gb));
            chk("vec_en", wt_en_out, 32'(vecs[i].en));
            chk("vec_addr", wt_addr_out, 32'(vecs[i].addr));
            chk("vec_data", wt_data_out, 32'(vecs[i].data));
        end

        async_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i), 8'hEE, 0);
            chk("fill_addr", wt_addr_out, i);
            chk("fill_full", wt_full, 32'(i == 15));
        end
        for (int i = 1; i <= 5; i++) begin
            step(1, 0, 8'hAA, 8'hBB, 0);
            chk("drop_gnt", s_ga, 0);
            chk("drop_cnt", wt_drop_cnt, i);
        end
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 8'h00, 8'h00, 1);
            chk("unfull_edge", wt_full, 32'(i < 3));
        end
        step(1, 0, 8'h5C, 8'h00, 1);
        chk("refill_en", wt_en_out, 1);
        chk("refill_addr", wt_addr_out, 0);
        chk("refill_data", wt_data_out, 8'h5C);
        chk("refill_full", wt_full, 1);
        for (int i = 0; i < 260; i++) step(0, 1, 8'h00, 8'h33, 1);
        chk("drop_saturate", wt_drop_cnt, 255);

        async_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 8'(i), 8'(i + 100), 0);
        async_reset();
        chk("after_rst_drop", wt_drop_cnt, 0);

        for (int i = 1; i <= 32; i++) begin
            m_rd = m_w;
            step(1, 0, 8'(i), 8'h00, m_rd);
            chk("wrap_full", wt_full, 0);
            if (i == 31) chk("wrap_gray31", wt_ptr_gray_out, 5'b10000);
            if (i == 32) chk("wrap_gray0", wt_ptr_gray_out, 5'b00000);
        end

        async_reset();
        for (int i = 0; i < 800; i++) begin
            if (m_rd != m_w && $urandom % 3 == 0) m_rd = (m_rd + 1) % 32;
            step(($urandom % 10) < 6, ($urandom % 10) < 6, 8'($urandom), 8'($urandom), m_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wt_port_arb.md
WT_PORT_ARB -- requirements
Module: wt_port_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, meaning memory address width; FIFO depth 2**ADDR_WIDTH; pointers ADDR_WIDTH+1 bits.
REQ-002 Parameter DATA_WIDTH, default 8, meaning write data width.
REQ-003 wt_clk_arb  input  1  write-domain clock; all state on rising edge.
REQ-004 rst_n_wt_arb_in  input  1  asynchronous, active-low reset.
REQ-005 req_a, req_b  input  1 each  write requests from requesters A and B.
REQ-006 data_a, data_b  input  DATA_WIDTH each  write data of A and B.
REQ-007 rd_ptr_gray_in  input  ADDR_WIDTH+1  Gray read pointer from read clock domain, asynchronous to wt_clk_arb.
REQ-008 gnt_a, gnt_b  output  1 each  combinational accept; at most one high per cycle.
REQ-009 wt_en_out  output  1  registered memory write strobe.
REQ-010 wt_addr_out  output  ADDR_WIDTH  registered memory write address.
REQ-011 wt_data_out  output  DATA_WIDTH  registered memory write data.
REQ-012 wt_ptr_gray_out  output  ADDR_WIDTH+1  registered Gray write pointer for the read domain.
REQ-013 wt_full  output  1  registered full flag.
REQ-014 wt_drop_cnt  output  8  saturating count of requests refused while full.

Function
REQ-015 Accept condition: at least one req high and wt_full=0; otherwise gnt_a=gnt_b=0.
REQ-016 Round-robin: one requester -> it wins; both -> the one not granted last wins; last_gnt updates only on accept.
REQ-017 On accepting edge: wt_en_out=1, wt_addr_out=wptr_bin[ADDR_WIDTH-1:0] (pre-increment), wt_data_out=winner data; one-cycle latency from grant.
REQ-018 No accept -> wt_en_out=0 next cycle; wt_addr_out and wt_data_out hold.
REQ-019 wptr_bin increments by 1 per accept, modulo 2**(ADDR_WIDTH+1); 31->0 for ADDR_WIDTH=4.
REQ-020 wt_ptr_gray_out = wptr_next ^ (wptr_next>>1), registered with wptr_bin.
REQ-021 rd_ptr_gray_in passes through a 2-flop synchronizer (rsync) before use.
REQ-022 wt_full registered = (gray(wptr_next) == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}); asserts on the edge of the filling write.
REQ-023 Read-pointer advance clears wt_full on the 3rd rising edge after rd_ptr_gray_in changes (2 sync + 1 compare).
REQ-024 Any req high while wt_full=1 -> wt_drop_cnt+1 per cycle (both high counts 1), saturating at 255.
REQ-025 Request present and full clearing same cycle: refused that cycle (registered full governs).

Reset
REQ-026 Reset low -> immediately: wptr_bin=0, wt_ptr_gray_out=0, rsync stages=0, wt_full=0, wt_en_out=0, wt_addr_out=0, wt_data_out=0, wt_drop_cnt=0, last_gnt=B (A wins first tie).
REQ-027 Reset mid-operation aborts pending write; gnt_a/gnt_b low while reset is asserted.
REQ-028 After release, first accept possible on first rising edge.

Structure
REQ-029 Shared package wt_fifo_pkg holds ADDR_WIDTH/DATA_WIDTH defaults and bin2gray function.
REQ-030 One sub-module ptr_sync_2ff (parameterised width, async active-low reset) implements REQ-021.
REQ-031 Arbiter, pointer, full logic and drop counter reside in wt_port_arb, ~150-250 lines.

Verification (ADDR_WIDTH=4, 10 ns clock)
REQ-032 Reset low 0-7 ns, release 7 ns -> all outputs 0, wt_full=0; first req_a at 15 ns granted, wt_addr_out=0 after edge.
REQ-033 req_a held, rd_ptr_gray_in=0 -> 16 accepts, addresses 0..15; wt_full=1 after 16th; next cycles no grant, wt_drop_cnt increments 1/cycle.
REQ-034 req_a=req_b=1 continuously -> grants A,B,A,B...; wt_data_out alternates data_a/data_b.
REQ-035 Full, then rd_ptr_gray_in=5'b00001 -> wt_full=0 on 3rd edge, exactly one more accept, then full again.
REQ-036 Wrap: 32 accepts with read pointer tracking -> wt_ptr_gray_out 5'b10000 (ptr 31) -> 5'b00000, wt_full never 1.
REQ-037 Reset asserted asynchronously mid-burst (e.g. 103 ns) -> outputs 0 before next edge; drop counter 0.
